// File: rtl/usb_rx_sequencer.sv
// USB receive-path sequencer: hunts SYNC inside a listen window, frames packet bits
// for the decoder with a one-bit hold so the last bit can be tagged at SE0, then checks EOP.
module usb_rx_sequencer #(
   parameter int TIMEOUT_BITS = 18,
   parameter int MAX_BITS     = 8208,
   parameter int CNT_W        = $clog2(MAX_BITS + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_enable,
   input  logic sample_en,
   input  logic dbit,
   input  logic se0,
   input  logic stuff_drop,
   output logic dec_valid,
   output logic dec_bit,
   output logic dec_start,
   output logic dec_end,
   output logic rx_busy,
   output logic rx_done,
   output logic rx_timeout,
   output logic rx_abort
);

   // bit 1 of the encoding doubles as the busy flag (RECV and EOP)
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_HUNT = 2'b01;
   localparam logic [1:0] S_RECV = 2'b10;
   localparam logic [1:0] S_EOP  = 2'b11;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_BITS - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(MAX_BITS - 1);

   logic [1:0]       state;
   logic [7:0]       sync_sr;
   logic [7:0]       sync_nxt;
   logic [CNT_W-1:0] tcnt;
   logic [CNT_W-1:0] bit_cnt;
   logic [1:0]       se_cnt;
   logic             hold;
   logic             hold_full;
   logic             first_flag;

   assign sync_nxt = {sync_sr[6:0], dbit};
   assign rx_busy  = state[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sync_sr    <= 8'hFF;
         tcnt       <= '0;
         bit_cnt    <= '0;
         se_cnt     <= '0;
         hold       <= 1'b0;
         hold_full  <= 1'b0;
         first_flag <= 1'b0;
         dec_valid  <= 1'b0;
         dec_bit    <= 1'b0;
         dec_start  <= 1'b0;
         dec_end    <= 1'b0;
         rx_done    <= 1'b0;
         rx_timeout <= 1'b0;
         rx_abort   <= 1'b0;
      end else begin
         dec_valid  <= 1'b0;
         dec_start  <= 1'b0;
         dec_end    <= 1'b0;
         rx_done    <= 1'b0;
         rx_timeout <= 1'b0;
         rx_abort   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_enable) begin
                  state   <= S_HUNT;
                  tcnt    <= '0;
                  sync_sr <= 8'hFF;
               end
            end
            S_HUNT: begin
               if (sample_en) begin
                  if (!rx_enable) begin
                     state <= S_IDLE;
                  end else if (se0) begin
                     sync_sr <= 8'hFF;
                  end else if (!stuff_drop) begin
                     sync_sr <= sync_nxt;
                     if (sync_nxt == 8'h01) begin
                        state     <= S_RECV;
                        bit_cnt   <= '0;
                        hold_full <= 1'b0;
                     end else if (tcnt == TMO_LAST) begin
                        rx_timeout <= 1'b1;
                        state      <= S_IDLE;
                     end else begin
                        tcnt <= tcnt + 1'b1;
                     end
                  end
               end
            end
            S_RECV: begin
               if (sample_en) begin
                  if (se0) begin
                     // held bit is the last one; packet length bit_cnt+1 must be a whole number of bytes
                     if (hold_full && (bit_cnt[2:0] == 3'd7)) begin
                        dec_valid <= 1'b1;
                        dec_bit   <= hold;
                        dec_start <= first_flag;
                        dec_end   <= 1'b1;
                        state     <= S_EOP;
                        se_cnt    <= 2'd1;
                     end else begin
                        rx_abort <= 1'b1;
                        state    <= S_IDLE;
                     end
                     hold_full <= 1'b0;
                  end else if (!stuff_drop) begin
                     if (!hold_full) begin
                        hold       <= dbit;
                        hold_full  <= 1'b1;
                        first_flag <= 1'b1;
                     end else if (bit_cnt >= BIT_LAST) begin
                        rx_abort  <= 1'b1;
                        state     <= S_IDLE;
                        hold_full <= 1'b0;
                     end else begin
                        dec_valid  <= 1'b1;
                        dec_bit    <= hold;
                        dec_start  <= first_flag;
                        hold       <= dbit;
                        first_flag <= 1'b0;
                        bit_cnt    <= bit_cnt + 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (sample_en) begin
                  if (se0) begin
                     if (se_cnt == 2'd2) begin
                        rx_abort <= 1'b1;
                        state    <= S_IDLE;
                     end else begin
                        se_cnt <= se_cnt + 2'd1;
                     end
                  end else if (!stuff_drop) begin
                     if (dbit && (se_cnt == 2'd2)) begin
                        rx_done <= 1'b1;
                        if (rx_enable) begin
                           state   <= S_HUNT;
                           tcnt    <= '0;
                           sync_sr <= 8'hFF;
                        end else begin
                           state <= S_IDLE;
                        end
                     end else begin
                        rx_abort <= 1'b1;
                        state    <= S_IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Bench for usb_rx_sequencer: a queue-based packet model predicts every output each cycle,
// and hand-computed packet totals pin the model on the directed scenarios.
module tb_usb_rx_sequencer;
   localparam int MAXB = 8208;
   localparam int TMO  = 18;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_enable = 1'b0;
   logic sample_en = 1'b0;
   logic dbit = 1'b0;
   logic se0 = 1'b0;
   logic stuff_drop = 1'b0;
   logic dec_valid, dec_bit, dec_start, dec_end, rx_busy, rx_done, rx_timeout, rx_abort;

   usb_rx_sequencer #(.TIMEOUT_BITS(TMO), .MAX_BITS(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .sample_en(sample_en),
      .dbit(dbit), .se0(se0), .stuff_drop(stuff_drop),
      .dec_valid(dec_valid), .dec_bit(dec_bit), .dec_start(dec_start), .dec_end(dec_end),
      .rx_busy(rx_busy), .rx_done(rx_done), .rx_timeout(rx_timeout), .rx_abort(rx_abort)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // packed as {valid, bit, start, end, busy, done, timeout, abort}
   logic [7:0] act;
   logic [7:0] exp_next = 8'h00;
   logic [7:0] exp_cur;
   logic [7:0] cmp_mask;
   assign act = {dec_valid, dec_bit, dec_start, dec_end, rx_busy, rx_done, rx_timeout, rx_abort};

   always @(posedge clk or negedge rst_n)
      if (!rst_n) exp_cur <= 8'h00;
      else        exp_cur <= exp_next;

   int n_valid, n_start, n_end, n_done, n_tmo, n_abort, start_idx, end_idx;
   logic [31:0] word;

   always @(negedge clk) begin
      if (rst_n) begin
         cmp_mask = exp_cur[7] ? 8'hFF : 8'hBF;
         checks++;
         if ((act & cmp_mask) !== (exp_cur & cmp_mask)) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got=%b want=%b (v,b,s,e,busy,done,tmo,abort)",
                     $time, act, exp_cur);
         end
         if (dec_start) start_idx = n_valid;
         if (dec_end)   end_idx = n_valid;
         if (dec_valid) begin
            if (n_valid < 32) word[n_valid] = dec_bit;
            n_valid++;
         end
         if (dec_start)  n_start++;
         if (dec_end)    n_end++;
         if (rx_done)    n_done++;
         if (rx_timeout) n_tmo++;
         if (rx_abort)   n_abort++;
      end
   end

   // behavioural model: phase 0 idle, 1 hunting, 2 in packet, 3 after last bit
   int         ph = 0;
   logic [7:0] win = 8'hFF;
   int         tcnt = 0;
   int         nse = 0;
   logic       q[$];

   task automatic model_reset();
      ph = 0; win = 8'hFF; tcnt = 0; nse = 0; q.delete();
   endtask

   task automatic model_step();
      logic [7:0] e;
      int n;
      e = 8'h00;
      if (ph == 0) begin
         if (rx_enable) begin ph = 1; win = 8'hFF; tcnt = 0; end
      end else if (sample_en) begin
         if (ph == 1) begin
            if (!rx_enable) ph = 0;
            else if (se0) win = 8'hFF;
            else if (!stuff_drop) begin
               win = {win[6:0], dbit};
               if (win == 8'h01) begin ph = 2; q.delete(); end
               else begin
                  tcnt++;
                  if (tcnt == TMO) begin e[1] = 1'b1; ph = 0; end
               end
            end
         end else if (ph == 2) begin
            n = q.size();
            if (se0) begin
               if (n >= 8 && n % 8 == 0) begin
                  e[7] = 1'b1; e[6] = q[n-1]; e[5] = (n == 1); e[4] = 1'b1;
                  ph = 3; nse = 1;
               end else begin
                  e[0] = 1'b1; ph = 0;
               end
               q.delete();
            end else if (!stuff_drop) begin
               if (n + 1 > MAXB) begin e[0] = 1'b1; ph = 0; q.delete(); end
               else begin
                  if (n > 0) begin e[7] = 1'b1; e[6] = q[n-1]; e[5] = (n == 1); end
                  q.push_back(dbit);
               end
            end
         end else begin
            if (se0) begin
               nse++;
               if (nse > 2) begin e[0] = 1'b1; ph = 0; end
            end else if (!stuff_drop) begin
               if (dbit && nse == 2) begin
                  e[2] = 1'b1;
                  if (rx_enable) begin ph = 1; win = 8'hFF; tcnt = 0; end
                  else ph = 0;
               end else begin
                  e[0] = 1'b1; ph = 0;
               end
            end
         end
      end
      e[3] = (ph >= 2);
      exp_next = e;
   endtask

   task automatic cyc(input logic en, input logic s, input logic z, input logic d, input logic st);
      @(posedge clk);
      #1;
      rx_enable = en; sample_en = s; se0 = z; dbit = d; stuff_drop = st;
      model_step();
   endtask

   task automatic bt(input logic en, input logic z, input logic d, input logic st);
      cyc(en, 1'b1, z, d, st);
      repeat (3) cyc(en, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_sync();
      repeat (7) bt(1'b1, 1'b0, 1'b0, 1'b0);
      bt(1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) bt(1'b1, 1'b0, b[i], 1'b0);
   endtask

   task automatic good_eop();
      bt(1'b1, 1'b1, 1'b0, 1'b0);
      bt(1'b1, 1'b1, 1'b0, 1'b0);
      bt(1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic go_idle();
      bt(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_counts();
      n_valid = 0; n_start = 0; n_end = 0; n_done = 0; n_tmo = 0; n_abort = 0;
      start_idx = -1; end_idx = -1; word = 32'h0;
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   task automatic ack_packet(input string tag);
      clear_counts();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_sync();
      send_byte(8'hD2);
      good_eop();
      chk({tag, "_valid_count"}, n_valid, 8);
      chk({tag, "_pid"}, int'(word[7:0]), 8'hD2);
      chk({tag, "_done"}, n_done, 1);
      chk({tag, "_abort"}, n_abort, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w16;
      logic [11:0] w12;
      clear_counts();
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("reset_outputs", int'(act), 0);
      #1 rst_n = 1'b1;

      // ACK handshake, start/end placement
      ack_packet("ack");
      chk("ack_start_idx", start_idx, 0);
      chk("ack_end_idx", end_idx, 7);
      chk("ack_start_count", n_start, 1);
      chk("ack_end_count", n_end, 1);

      // 16-bit packet with a stuffed zero after six ones
      clear_counts();
      send_sync();
      w16 = 16'h0F3F;
      for (int i = 0; i < 16; i++) begin
         bt(1'b1, 1'b0, w16[i], 1'b0);
         if (i == 5) bt(1'b1, 1'b0, 1'b0, 1'b1);
      end
      good_eop();
      chk("stuff_valid_count", n_valid, 16);
      chk("stuff_word", int'(word[15:0]), 16'h0F3F);
      chk("stuff_done", n_done, 1);

      // timeout on the 18th idle-J bit time
      go_idle();
      clear_counts();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (17) bt(1'b1, 1'b0, 1'b1, 1'b0);
      chk("tmo_before_18", n_tmo, 0);
      bt(1'b1, 1'b0, 1'b1, 1'b0);
      chk("tmo_at_18", n_tmo, 1);
      chk("tmo_no_valid", n_valid, 0);
      go_idle();

      // 12 bits then SE0: misaligned length
      clear_counts();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_sync();
      w12 = 12'hA5C;
      for (int i = 0; i < 12; i++) bt(1'b1, 1'b0, w12[i], 1'b0);
      bt(1'b1, 1'b1, 1'b0, 1'b0);
      chk("short12_abort", n_abort, 1);
      chk("short12_valid", n_valid, 11);
      chk("short12_end", n_end, 0);
      bt(1'b1, 1'b0, 1'b1, 1'b0);
      chk("short12_done", n_done, 0);
      go_idle();

      // SE0 restarts the hunt, then a byte with a one-SE0 EOP
      clear_counts();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (7) bt(1'b1, 1'b0, 1'b0, 1'b0);
      bt(1'b1, 1'b1, 1'b0, 1'b0);
      bt(1'b1, 1'b0, 1'b1, 1'b0);
      send_sync();
      send_byte(8'h4B);
      bt(1'b1, 1'b1, 1'b0, 1'b0);
      bt(1'b1, 1'b0, 1'b1, 1'b0);
      chk("eop_valid", n_valid, 8);
      chk("eop_byte", int'(word[7:0]), 8'h4B);
      chk("eop_end", n_end, 1);
      chk("eop_abort", n_abort, 1);
      chk("eop_done", n_done, 0);
      go_idle();

      // asynchronous reset while a bit strobe is on the output
      clear_counts();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_sync();
      for (int i = 0; i < 4; i++) bt(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("prereset_valid", int'(dec_valid), 1);
      chk("prereset_busy", int'(rx_busy), 1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", int'(act), 0);
      rx_enable = 1'b0; sample_en = 1'b0; se0 = 1'b0; dbit = 1'b0; stuff_drop = 1'b0;
      model_reset();
      exp_next = 8'h00;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      ack_packet("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
